multicycle_control: RTL



---
 rtl/mips_ctrl_pkg.sv | 69 ++++++
 rtl/mem_wait_timer.sv | 33 +++
 rtl/multicycle_control.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM.
package mips_ctrl_pkg;

    // Instruction opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    // Control states; encodings 12..15 are unused and recover to FETCH
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDIEXEC = 4'd10,
        S_ADDIWB   = 4'd11
    } state_e;

    // ALU operand B select
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALUOp to ALU_Control
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Full control word driven to the datapath
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
        logic       mem_timeout;
    } ctrl_t;

    // States that wait on the memory ready handshake
    function automatic logic is_mem_state(state_e s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles in a memory state and flags the abort cycle.
module mem_wait_timer #(
    parameter int WAIT_W   = 4,
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic waiting,
    output logic expired
);

    localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_MAX[WAIT_W-1:0];

    logic [WAIT_W-1:0] cnt_q, cnt_d;

    // Abort only when still not ready after WAIT_MAX stalled cycles
    assign expired = waiting && (cnt_q == MAX_CNT);

    // Expiry clears the count itself so a FETCH restart (no state change) starts fresh
    always_comb begin
        cnt_d = cnt_q;
        if (clear || expired) cnt_d = '0;
        else if (waiting)     cnt_d = cnt_q + 1'b1;
    end

    // Counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int WAIT_W   = 4,
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ALUOp1,
    output logic       ALUOp0,
    output logic [1:0] PCSource,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_timeout
);

    state_e state_q, state_d;
    ctrl_t  ctl, ctl_o;
    logic   waiting, expired, illegal;

    assign waiting = is_mem_state(state_q) && !mem_ready;

    mem_wait_timer #(.WAIT_W(WAIT_W), .WAIT_MAX(WAIT_MAX)) u_wait (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state_d != state_q),
        .waiting (waiting),
        .expired (expired)
    );

    // Next-state selection; a memory-wait abort overrides everything
    always_comb begin
        state_d = state_q;
        illegal = 1'b0;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:    if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWR:    if (mem_ready) state_d = S_FETCH;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_ADDIEXEC: state_d = S_ADDIWB;
            S_ADDIWB:   state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
        if (expired) state_d = S_FETCH;
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    // Moore decode of the control word; FETCH write enables wait for mem_ready
    always_comb begin
        ctl             = '0;
        ctl.illegal_op  = illegal;
        ctl.mem_timeout = expired;
        case (state_q)
            S_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = SRCB_FOUR;
                ctl.ir_write  = mem_ready;
                ctl.pc_write  = mem_ready;
            end
            S_DECODE:   ctl.alu_src_b = SRCB_IMMSH2;
            S_MEMADR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctl.mem_read = 1'b1;
                ctl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctl.mem_to_reg = 1'b1;
                ctl.reg_write  = 1'b1;
                ctl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctl.mem_write  = 1'b1;
                ctl.iord       = 1'b1;
                ctl.instr_done = mem_ready;
            end
            S_EXECUTE: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctl.reg_dst    = 1'b1;
                ctl.reg_write  = 1'b1;
                ctl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctl.alu_src_a     = 1'b1;
                ctl.alu_op        = ALUOP_SUB;
                ctl.pc_write_cond = 1'b1;
                ctl.pc_source     = PCSRC_ALUOUT;
                ctl.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctl.pc_write   = 1'b1;
                ctl.pc_source  = PCSRC_JUMP;
                ctl.instr_done = 1'b1;
            end
            S_ADDIEXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: begin
                ctl.reg_write  = 1'b1;
                ctl.instr_done = 1'b1;
            end
            default: ctl = '0;
        endcase
    end

    // Reset masks every output immediately, independent of the clock
    assign ctl_o = reset_n ? ctl : '0;

    assign PCWrite     = ctl_o.pc_write;
    assign PCWriteCond = ctl_o.pc_write_cond;
    assign IorD        = ctl_o.iord;
    assign MemRead     = ctl_o.mem_read;
    assign MemWrite    = ctl_o.mem_write;
    assign IRWrite     = ctl_o.ir_write;
    assign MemtoReg    = ctl_o.mem_to_reg;
    assign RegDst      = ctl_o.reg_dst;
    assign RegWrite    = ctl_o.reg_write;
    assign ALUSrcA     = ctl_o.alu_src_a;
    assign ALUSrcB     = ctl_o.alu_src_b;
    assign ALUOp1      = ctl_o.alu_op[1];
    assign ALUOp0      = ctl_o.alu_op[0];
    assign PCSource    = ctl_o.pc_source;
    assign instr_done  = ctl_o.instr_done;
    assign illegal_op  = ctl_o.illegal_op;
    assign mem_timeout = ctl_o.mem_timeout;

endmodule
